// File: rtl/lc3_arb_pkg.sv
// lc3_arb_pkg: shared types and defaults for the LC-3 single-port memory arbiter.
//   arb_state_t : sequencer states (IDLE, ACCESS, DONE)
//   req_id_t    : requester id, REQ_CPU = 0, REQ_DMA = 1
//   DEF_*       : default widths and wait-state count
//   CNT_W       : wait counter width (covers 0..15 wait states)
package lc3_arb_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_WAIT_CYCLES = 1;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CPU = 1'b0;
    localparam req_id_t REQ_DMA = 1'b1;

endpackage

// File: rtl/lc3_arb_pick.sv
// lc3_arb_pick: combinational winner selection between the CPU and DMA requesters.
//   cpu_req, dma_req : request lines
//   last_gnt         : requester granted most recently (round-robin only)
//   any_req          : at least one request pending
//   winner           : selected requester id
// Build option: LC3_ARB_RR_EN selects round-robin on ties; otherwise the CPU always
// wins and last_gnt is ignored.
module lc3_arb_pick
    import lc3_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  req_id_t last_gnt,
    output logic    any_req,
    output req_id_t winner
);

    always_comb begin
        any_req = cpu_req | dma_req;
`ifdef LC3_ARB_RR_EN
        // On a tie the requester that was not served last goes next.
        if (cpu_req && dma_req) begin
            winner = (last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else begin
            winner = cpu_req ? REQ_CPU : REQ_DMA;
        end
`else
        winner = cpu_req ? REQ_CPU : REQ_DMA;
`endif
    end

`ifndef LC3_ARB_RR_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one memory port between the CPU load/store path and a
// DMA/program-loader requester. Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles)
// -> DONE, where the winner gets a one-cycle ack with its read data.
//   clk, rst                         : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata : CPU requester
//   dma_req/we/addr/wdata, dma_ack/rdata : DMA requester
//   mem_addr/wdata/we/en, mem_rdata  : memory port
//   busy                             : not in IDLE
//   gnt_id                           : current or last granted requester (0 CPU, 1 DMA)
// Build option: LC3_ARB_RR_EN enables round-robin arbitration (default fixed priority).
// All outputs are registered.
module lc3_mem_arbiter
    import lc3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output req_id_t           gnt_id
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             any_req;
    req_id_t          winner;
    req_id_t          last_gnt;

`ifdef LC3_ARB_RR_EN
    // Separate pointer: it resets to DMA so the CPU wins the first tie, while
    // gnt_id itself resets to CPU.
    req_id_t last_q;
    assign last_gnt = last_q;
`else
    assign last_gnt = gnt_id;
`endif

    lc3_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .last_gnt (last_gnt),
        .any_req  (any_req),
        .winner   (winner)
    );

    // The mem_* registers double as the latched request, so later changes on the
    // requester inputs cannot reach the memory port mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_en    <= 1'b0;
            busy      <= 1'b0;
            gnt_id    <= REQ_CPU;
`ifdef LC3_ARB_RR_EN
            last_q    <= REQ_DMA;
`endif
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= ACCESS;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        cnt_q   <= WAIT_CNT;
                        gnt_id  <= winner;
`ifdef LC3_ARB_RR_EN
                        last_q  <= winner;
`endif
                        if (winner == REQ_CPU) begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_we    <= cpu_we;
                        end else begin
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                            mem_we    <= dma_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if (gnt_id == REQ_CPU) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= mem_rdata;
                        end else begin
                            dma_ack   <= 1'b1;
                            dma_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
